// File: rtl/instruction_text_renderer.sv
`default_nettype none
// ============================================================================
// Module   : instruction_text_renderer
// Purpose  : Display-side reader of the 64 x 32-bit graphic instruction
//            memory. Scans the pixel position, reads the entry under the
//            beam and renders it as 8 hex glyphs (8x8 font). The result is
//            one RGB332 pixel per clock with a fixed 3-clock latency.
//
// Ports    : CLK          pixel clock
//            RST          asynchronous active-low reset
//            SYS_X/SYS_Y  current pixel column / line
//            INS_COUNT    number of valid entries (0..64, larger = 64)
//            NEW_INS_ADD  next write address of the capture path
//            RD_EN        memory read strobe
//            RD_ADDR      memory read address
//            RD_DATA      memory read data (valid the cycle after RD_EN)
//            ACTIVE       pixel lies inside a drawn text cell
//            COLOR        RGB332 pixel colour
//
// Options  : HIGHLIGHT_LAST_EN - when defined, the most recently written
//            entry ((NEW_INS_ADD-1) mod 64) is drawn with inverted colours.
//            When undefined NEW_INS_ADD is ignored.
//
// Revision : 1.0 - initial release
// ============================================================================
module instruction_text_renderer #(
    parameter int         X0    = 16,
    parameter int         ROW_H = 15,
    parameter logic [7:0] FG    = 8'hFF,
    parameter logic [7:0] BG    = 8'h00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  SYS_X,
    input  logic [9:0]  SYS_Y,
    input  logic [6:0]  INS_COUNT,
    input  logic [5:0]  NEW_INS_ADD,
    output logic        RD_EN,
    output logic [5:0]  RD_ADDR,
    input  logic [31:0] RD_DATA,
    output logic        ACTIVE,
    output logic [7:0]  COLOR
);

    localparam logic [9:0] c_VIS_W    = 10'd640;
    localparam logic [9:0] c_VIS_H    = 10'd480;
    localparam logic [9:0] c_LEFT_X0  = 10'(X0);
    localparam logic [9:0] c_RIGHT_X0 = 10'(X0 + 320);
    localparam logic [9:0] c_COL_W    = 10'd64;

    // ------------------------------------------------------------------
    // Position decode (combinational, feeds S1)
    // ------------------------------------------------------------------
    logic       w_visible;
    logic       w_left;
    logic       w_right;
    logic       w_in_col;
    logic [4:0] w_row;
    logic [9:0] w_line;
    logic [9:0] w_col_start;
    logic [2:0] w_char;
    logic [5:0] w_entry;

    assign w_visible   = (SYS_X < c_VIS_W) && (SYS_Y < c_VIS_H);
    assign w_left      = (SYS_X >= c_LEFT_X0)  && (SYS_X < c_LEFT_X0 + c_COL_W);
    assign w_right     = (SYS_X >= c_RIGHT_X0) && (SYS_X < c_RIGHT_X0 + c_COL_W);
    assign w_in_col    = (w_left || w_right) && w_visible;
    // Division by a constant; only meaningful inside the visible area.
    assign w_row       = 5'(SYS_Y / 10'(ROW_H));
    assign w_line      = SYS_Y % 10'(ROW_H);
    assign w_col_start = w_right ? c_RIGHT_X0 : c_LEFT_X0;
    assign w_char      = 3'((SYS_X - w_col_start) >> 3);
    // Right column holds entries 32..63.
    assign w_entry     = {w_right, w_row};

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [2:0] r_s1_char;
    logic [2:0] r_s1_bitpos;
    logic [2:0] r_s1_line;
    logic       r_s1_incell;

    logic [7:0] r_s2_glyph;
    logic [2:0] r_s2_bitpos;
    logic       r_s2_valid;

    // ------------------------------------------------------------------
    // S2 decode: nibble select and font lookup
    // ------------------------------------------------------------------
    logic [4:0]  w_nib_msb;
    logic [3:0]  w_nib;
    logic [63:0] w_glyph;
    logic [5:0]  w_row_msb;
    logic [7:0]  w_glyph_row;
    logic        w_entry_valid;

    // Character 0 takes the most significant nibble.
    assign w_nib_msb = 5'd31 - {r_s1_char, 2'b00};
    assign w_nib     = RD_DATA[w_nib_msb -: 4];

    // 8x8 hex font: byte 7 (MSBs) is line 0, bit 7 of each byte is the
    // leftmost pixel.
    always_comb begin
        w_glyph = 64'h0;
        case (w_nib)
            4'h0: w_glyph = 64'h3C666E7666663C00;
            4'h1: w_glyph = 64'h1838181818187E00;
            4'h2: w_glyph = 64'h3C66060C30607E00;
            4'h3: w_glyph = 64'h3C66061C06663C00;
            4'h4: w_glyph = 64'h0C1C3C6C7E0C0C00;
            4'h5: w_glyph = 64'h7E607C0606663C00;
            4'h6: w_glyph = 64'h3C66607C66663C00;
            4'h7: w_glyph = 64'h7E060C1818181800;
            4'h8: w_glyph = 64'h3C66663C66663C00;
            4'h9: w_glyph = 64'h3C66663E06663C00;
            4'hA: w_glyph = 64'h183C66667E666600;
            4'hB: w_glyph = 64'h7C66667C66667C00;
            4'hC: w_glyph = 64'h3C66606060663C00;
            4'hD: w_glyph = 64'h786C6666666C7800;
            4'hE: w_glyph = 64'h7E60607C60607E00;
            4'hF: w_glyph = 64'h7E60607C60606000;
            default: w_glyph = 64'h0;
        endcase
    end

    assign w_row_msb   = 6'd63 - {r_s1_line, 3'b000};
    assign w_glyph_row = w_glyph[w_row_msb -: 8];
    // RD_ADDR still holds this pixel's entry during S2. A 7-bit compare
    // makes any INS_COUNT above 64 behave as 64.
    assign w_entry_valid = ({1'b0, RD_ADDR} < INS_COUNT);

    // ------------------------------------------------------------------
    // Optional highlight of the most recently written entry
    // ------------------------------------------------------------------
    logic w_invert;

`ifdef HIGHLIGHT_LAST_EN
    logic [5:0] w_last_entry;
    logic       r_s1_hl;
    logic       r_s2_hl;

    // NEW_INS_ADD points at the next free slot; wraps so 0 selects 63.
    assign w_last_entry = NEW_INS_ADD - 6'd1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s1_hl <= 1'b0;
            r_s2_hl <= 1'b0;
        end else begin
            r_s1_hl <= (w_entry == w_last_entry) && (INS_COUNT != 7'd0);
            r_s2_hl <= r_s1_hl;
        end
    end

    assign w_invert = r_s2_hl;
`else
    logic w_unused_new_ins_add;

    assign w_unused_new_ins_add = ^NEW_INS_ADD;
    assign w_invert             = 1'b0;
`endif

    // ------------------------------------------------------------------
    // S1 / S2 / S3 pipeline
    // ------------------------------------------------------------------
    logic w_pix;

    assign w_pix = r_s2_glyph[3'd7 - r_s2_bitpos];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RD_EN       <= 1'b0;
            RD_ADDR     <= 6'd0;
            r_s1_char   <= 3'd0;
            r_s1_bitpos <= 3'd0;
            r_s1_line   <= 3'd0;
            r_s1_incell <= 1'b0;
            r_s2_glyph  <= 8'd0;
            r_s2_bitpos <= 3'd0;
            r_s2_valid  <= 1'b0;
            ACTIVE      <= 1'b0;
            COLOR       <= BG;
        end else begin
            // S1: issue the read and carry the position forward
            RD_EN       <= w_in_col;
            RD_ADDR     <= w_entry;
            r_s1_char   <= w_char;
            r_s1_bitpos <= SYS_X[2:0];
            r_s1_line   <= w_line[2:0];
            r_s1_incell <= w_in_col && (w_line < 10'd8);

            // S2: read data is present, decode into a glyph row
            r_s2_glyph  <= w_glyph_row;
            r_s2_bitpos <= r_s1_bitpos;
            r_s2_valid  <= r_s1_incell && w_entry_valid;

            // S3: pixel colour
            ACTIVE      <= r_s2_valid;
            COLOR       <= (r_s2_valid && (w_pix ^ w_invert)) ? FG : BG;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_text_renderer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_instruction_text_renderer
// Purpose  : Self-checking bench for instruction_text_renderer. Expected
//            pixels and read strobes come from a behavioural model and are
//            queued with the cycle they are due; the DUT outputs are
//            compared when that cycle arrives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_text_renderer;

    localparam logic [7:0] c_FG = 8'hFF;
    localparam logic [7:0] c_BG = 8'h00;

    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  SYS_X;
    logic [9:0]  SYS_Y;
    logic [6:0]  INS_COUNT;
    logic [5:0]  NEW_INS_ADD;
    logic        RD_EN;
    logic [5:0]  RD_ADDR;
    logic [31:0] RD_DATA;
    logic        ACTIVE;
    logic [7:0]  COLOR;

    logic [31:0] mem  [64];
    logic [63:0] font [16];

    // Memory read port: data for the registered address is presented in
    // the cycle following the strobe.
    assign RD_DATA = mem[RD_ADDR];

    instruction_text_renderer #(
        .X0    (16),
        .ROW_H (15),
        .FG    (c_FG),
        .BG    (c_BG)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SYS_X       (SYS_X),
        .SYS_Y       (SYS_Y),
        .INS_COUNT   (INS_COUNT),
        .NEW_INS_ADD (NEW_INS_ADD),
        .RD_EN       (RD_EN),
        .RD_ADDR     (RD_ADDR),
        .RD_DATA     (RD_DATA),
        .ACTIVE      (ACTIVE),
        .COLOR       (COLOR)
    );

    always #5 CLK = ~CLK;

    typedef struct { int due; int x; int y; logic act; logic [7:0] col; } pix_t;
    typedef struct { int due; int x; int y; logic en;  logic [5:0] addr; } rd_t;

    pix_t pq[$];
    rd_t  rq[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Behavioural model of one pixel position.
    task automatic model(input int x, input int y,
                         output logic act, output logic [7:0] col,
                         output logic en, output logic [5:0] addr);
        int row, line, cs, entry, c, bp;
        bit vis, left, right, valid, pix, hl;
        logic [3:0] nib;
        logic [7:0] gr;
        vis   = (x < 640) && (y < 480);
        row   = y / 15;
        line  = y % 15;
        left  = (x >= 16)  && (x < 80);
        right = (x >= 336) && (x < 400);
        en    = vis && (left || right);
        entry = right ? row + 32 : row;
        addr  = 6'(entry);
        cs    = left ? 16 : 336;
        c     = (x - cs) / 8;
        bp    = x % 8;
        valid = en && (line < 8) && (entry < int'(INS_COUNT));
        pix   = 1'b0;
        if (valid) begin
            nib = 4'((mem[entry] >> (28 - 4 * c)) & 32'hF);
            gr  = 8'((font[nib] >> (8 * (7 - line))) & 64'hFF);
            pix = gr[7 - bp];
        end
        hl = 1'b0;
`ifdef HIGHLIGHT_LAST_EN
        hl = (INS_COUNT != 7'd0) && (entry == (int'(NEW_INS_ADD) + 63) % 64);
`endif
        act = valid;
        col = valid ? ((pix ^ hl) ? c_FG : c_BG) : c_BG;
    endtask

    // One clock: compare everything due now, then drive the next position.
    task automatic step(input bit push, input int x, input int y);
        pix_t p;
        rd_t  r;
        logic a;
        logic [7:0] c;
        logic e;
        logic [5:0] ad;
        @(posedge CLK);
        #1;
        cyc++;
        while (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            check($sformatf("rd_en@%0d,%0d", r.x, r.y), 32'(RD_EN), 32'(r.en));
            if (r.en) check($sformatf("rd_addr@%0d,%0d", r.x, r.y), 32'(RD_ADDR), 32'(r.addr));
        end
        while (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            check($sformatf("active@%0d,%0d", p.x, p.y), 32'(ACTIVE), 32'(p.act));
            check($sformatf("color@%0d,%0d", p.x, p.y), 32'(COLOR), 32'(p.col));
        end
        SYS_X = 10'(x);
        SYS_Y = 10'(y);
        if (push) begin
            model(x, y, a, c, e, ad);
            rq.push_back('{cyc + 1, x, y, e, ad});
            pq.push_back('{cyc + 3, x, y, a, c});
        end
    endtask

    task automatic drain();
        repeat (4) step(1'b0, 700, 500);
    endtask

    task automatic sweep(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                step(1'b1, x, y);
        drain();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_en"},   32'(RD_EN),   32'd0);
        check({tag, "_rd_addr"}, 32'(RD_ADDR), 32'd0);
        check({tag, "_active"},  32'(ACTIVE),  32'd0);
        check({tag, "_color"},   32'(COLOR),   32'(c_BG));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        font[0]  = 64'h3C666E7666663C00;  font[1]  = 64'h1838181818187E00;
        font[2]  = 64'h3C66060C30607E00;  font[3]  = 64'h3C66061C06663C00;
        font[4]  = 64'h0C1C3C6C7E0C0C00;  font[5]  = 64'h7E607C0606663C00;
        font[6]  = 64'h3C66607C66663C00;  font[7]  = 64'h7E060C1818181800;
        font[8]  = 64'h3C66663C66663C00;  font[9]  = 64'h3C66663E06663C00;
        font[10] = 64'h183C66667E666600;  font[11] = 64'h7C66667C66667C00;
        font[12] = 64'h3C66606060663C00;  font[13] = 64'h786C6666666C7800;
        font[14] = 64'h7E60607C60607E00;  font[15] = 64'h7E60607C60606000;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        RST = 1'b0;  SYS_X = 10'd700;  SYS_Y = 10'd500;
        INS_COUNT = 7'd0;  NEW_INS_ADD = 6'd0;

        // Reset state with the clock running
        repeat (3) @(posedge CLK);
        #1;
        check_idle("reset");
        RST = 1'b1;

        // Latency / left column: entry 0 = 0123_4567
        mem[0] = 32'h0123_4567;  INS_COUNT = 7'd1;  NEW_INS_ADD = 6'd1;
        sweep(8, 90, 0, 7);

        // Right column: entry 33 all F's, every entry valid
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[33] = 32'hFFFF_FFFF;  INS_COUNT = 7'd64;  NEW_INS_ADD = 6'd10;
        sweep(330, 405, 15, 22);

        // Valid masking: row 4 drawn, row 5 blank
        mem[4] = 32'h89AB_CDEF;  mem[5] = 32'hDEAD_BEEF;  INS_COUNT = 7'd5;
        sweep(10, 90, 60, 89);

        // Blank lines and outside the visible area
        INS_COUNT = 7'd64;
        sweep(0, 100, 8, 14);
        sweep(636, 645, 0, 1);
        sweep(16, 30, 480, 481);
        sweep(795, 799, 523, 524);

        // Random positions under several entry counts (0, full, >64, partial)
        foreach (mem[i]) mem[i] = $urandom;
        for (int k = 0; k < 4; k++) begin
            INS_COUNT   = (k == 0) ? 7'd0 : (k == 1) ? 7'd64 : (k == 2) ? 7'd100 : 7'd37;
            NEW_INS_ADD = 6'($urandom_range(0, 63));
            for (int n = 0; n < 400; n++) begin
                int x, y;
                y = $urandom_range(0, 524);
                case ($urandom_range(0, 2))
                    0: x = $urandom_range(16, 79);
                    1: x = $urandom_range(336, 399);
                    default: x = $urandom_range(0, 799);
                endcase
                step(1'b1, x, y);
            end
            drain();
        end

        // Highlight of the last written entry (plain rendering when the
        // option is compiled out)
        INS_COUNT = 7'd3;  NEW_INS_ADD = 6'd3;
        sweep(10, 90, 30, 37);
        INS_COUNT = 7'd64;  NEW_INS_ADD = 6'd0;
        sweep(330, 405, 465, 472);

        // Asynchronous reset in the middle of a line
        INS_COUNT = 7'd64;
        mem[0] = 32'h8888_8888;
        for (int x = 16; x < 40; x++) step(1'b1, x, 0);
        #3;
        RST = 1'b0;
        #1;
        check_idle("async_rst");
        pq.delete();
        rq.delete();
        repeat (2) @(posedge CLK);
        #1;
        check_idle("rst_hold");
        RST = 1'b1;
        // Pixels driven after release appear exactly 3 clocks later
        for (int x = 16; x < 80; x++) step(1'b1, x, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_text_renderer.md
Name:
instruction_text_renderer

Overview:
- Display-side reader of the graphic instruction memory: turns the captured 64 x 32-bit instruction words into hex-text pixels for the VGA pipeline.
- The capture path writes words and advances the write address. This block scans the display position (SYS_X, SYS_Y), issues synchronous reads, decodes each word into 8 hex glyphs and emits one pixel per CLK.
- Sits between the memory read port and the VGA colour mux.

Parameters:
- X0, 16: left column start pixel; right column starts at X0+320.
- ROW_H, 15: text row pitch in lines; 32 rows x 15 = 480.
- FG, 8'hFF: foreground colour (RGB332).
- BG, 8'h00: background colour.

Ports:
- CLK  in  1  pixel clock; SYS_X/SYS_Y advance once per CLK.
- RST  in  1  asynchronous, active-low reset.
- SYS_X  in  10  current pixel column, 0..799.
- SYS_Y  in  10  current pixel line, 0..524.
- INS_COUNT  in  7  number of valid entries, 0..64.
- NEW_INS_ADD  in  6  next write address from the capture path.
- RD_EN  out  1  memory read strobe.
- RD_ADDR  out  6  memory read address.
- RD_DATA  in  32  memory data, valid 1 CLK after RD_EN.
- ACTIVE  out  1  pixel lies inside a text cell.
- COLOR  out  8  RGB332 pixel colour.

Behaviour:
- Reset (RST=0, async): all pipeline registers clear; RD_EN=0, RD_ADDR=0, ACTIVE=0, COLOR=BG. Output resumes 3 CLK after RST releases.
- Geometry:
  - Visible area is x<640, y<480.
  - row = SYS_Y / ROW_H (0..31); line = SYS_Y % ROW_H.
  - Left column: X0 <= x < X0+64, entry = row.
  - Right column: X0+320 <= x < X0+384, entry = row+32.
  - char c = (x - colstart) >> 3 (0..7); bitpos = x & 7.
- Stage S1 (edge n+1):
  - RD_ADDR <= entry.
  - RD_EN <= in-column and visible.
  - Register c, bitpos, line, in-cell flag. in-cell = in-column && line<8 && visible.
- Stage S2 (edge n+2):
  - nibble = RD_DATA[31-4c -: 4], so the MSB nibble is the leftmost glyph.
  - Register glyph row = internal font ROM[nibble][line] (16 glyphs 0-F, 8x8, bit7 = leftmost).
  - Register valid = in-cell && (entry < INS_COUNT).
- Stage S3 (edge n+3):
  - ACTIVE <= valid.
  - COLOR <= (valid && glyph[7-bitpos]) ? FG : BG.
- Latency: exactly 3 CLK from SYS_X/SYS_Y to COLOR/ACTIVE. The parent delays HS/VS by 3.
- Boundaries:
  - INS_COUNT=0: whole screen BG.
  - INS_COUNT=64: all entries drawn.
  - INS_COUNT>64: treated as 64.
  - Lines 8..ROW_H-1 of each row are blank.
  - Positions outside the visible area give ACTIVE=0 and COLOR=BG, with RD_EN=0.
- Write collision: a read of the address being written in the same cycle returns memory-defined data. That entry may show old or new content for one frame only; no stall.
- Reset mid-frame: output is BG until the pipeline refills; no state persists across frames.

Optional Feature:
- HIGHLIGHT_LAST_EN defined:
  - The most recently written entry, (NEW_INS_ADD-1) mod 64, is drawn inverted: glyph pixels BG, cell background FG, all 8 lines of ROW_H.
  - The comparison is pipelined with the entry, so latency stays 3.
  - If INS_COUNT=0, nothing is highlighted.
  - NEW_INS_ADD=0 highlights entry 63.
- HIGHLIGHT_LAST_EN undefined: no highlight logic; NEW_INS_ADD is unused.

Test Plan:
- Latency: entry0=32'h0123_4567, INS_COUNT=1. Sweep y=0, x=16..79 -> RD_ADDR=0 at +1 CLK; COLOR pattern matches glyphs "0..7" line0, delayed 3 CLK.
- Right column: entry33=32'hFFFF_FFFF, INS_COUNT=64. y=15..22, x=336..399 -> RD_ADDR=33; glyph 'F' rows on all 8 chars.
- Valid masking: INS_COUNT=5, entry5 nonzero -> row5 fully BG with ACTIVE=0; row4 drawn.
- Blank lines/out of range: y=8..14, x=640, y=480 -> ACTIVE=0, COLOR=BG, RD_EN=0.
- Async reset: assert RST=0 mid-line -> outputs BG/0 immediately without a clock edge; after release, first valid COLOR appears 3 CLK later.
- HIGHLIGHT_LAST_EN: NEW_INS_ADD=3, INS_COUNT=3 -> row2 inverted (background FF). NEW_INS_ADD=0, INS_COUNT=64 -> entry63 (right column, row31) inverted.
